// File: rtl/forwarding_unit_if.sv
// Bundle of M/W destination info, D/E source registers, bypass selects and event counters.
// The pipeline side drives the register fields; the forwarding unit answers with selects and counts.
interface forwarding_unit_if #(
    parameter int CNT_W = 16
);
    logic             regwriteM;
    logic             regwriteW;
    logic [4:0]       rsD;
    logic [4:0]       rtD;
    logic [4:0]       rsE;
    logic [4:0]       rtE;
    logic [4:0]       writeregM;
    logic [4:0]       writeregW;
    logic             forwardaD;
    logic             forwardbD;
    logic [1:0]       forwardaE;
    logic [1:0]       forwardbE;
    logic [CNT_W-1:0] fwd_cnt_D;
    logic [CNT_W-1:0] fwd_cnt_EM;
    logic [CNT_W-1:0] fwd_cnt_EW;

    modport master (
        output regwriteM, regwriteW, rsD, rtD, rsE, rtE, writeregM, writeregW,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  fwd_cnt_D, fwd_cnt_EM, fwd_cnt_EW
    );

    modport slave (
        input  regwriteM, regwriteW, rsD, rtD, rsE, rtE, writeregM, writeregW,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output fwd_cnt_D, fwd_cnt_EM, fwd_cnt_EW
    );
endinterface

// File: rtl/forwarding_unit.sv
// Operand bypass selects for D and E stages (combinational, zero latency, no backpressure),
// plus saturating forwarding-event counters updated on each clock edge.
module forwarding_unit #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    forwarding_unit_if.slave fu
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             fwd_a_d;
    logic             fwd_b_d;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
    logic             ev_d;
    logic             ev_em;
    logic             ev_ew;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_em;
    logic [CNT_W-1:0] cnt_ew;

    // M wins over W because it holds the younger result; $0 is hardwired zero.
    function automatic logic [1:0] exe_sel(
        input logic [4:0] src,
        input logic [4:0] dst_m,
        input logic       we_m,
        input logic [4:0] dst_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0 && src == dst_m && we_m)
            sel = 2'b10;
        else if (src != 5'd0 && src == dst_w && we_w)
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        fwd_a_d = (fu.rsD != 5'd0) && (fu.rsD == fu.writeregM) && fu.regwriteM;
        fwd_b_d = (fu.rtD != 5'd0) && (fu.rtD == fu.writeregM) && fu.regwriteM;
        fwd_a_e = exe_sel(fu.rsE, fu.writeregM, fu.regwriteM, fu.writeregW, fu.regwriteW);
        fwd_b_e = exe_sel(fu.rtE, fu.writeregM, fu.regwriteM, fu.writeregW, fu.regwriteW);
    end

    assign ev_d  = fwd_a_d | fwd_b_d;
    assign ev_em = (fwd_a_e == 2'b10) || (fwd_b_e == 2'b10);
    assign ev_ew = (fwd_a_e == 2'b01) || (fwd_b_e == 2'b01);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_d  <= '0;
            cnt_em <= '0;
            cnt_ew <= '0;
        end else begin
            if (ev_d && cnt_d != CNT_MAX)
                cnt_d <= cnt_d + 1'b1;
            if (ev_em && cnt_em != CNT_MAX)
                cnt_em <= cnt_em + 1'b1;
            if (ev_ew && cnt_ew != CNT_MAX)
                cnt_ew <= cnt_ew + 1'b1;
        end
    end

    assign fu.forwardaD  = fwd_a_d;
    assign fu.forwardbD  = fwd_b_d;
    assign fu.forwardaE  = fwd_a_e;
    assign fu.forwardbE  = fwd_b_e;
    assign fu.fwd_cnt_D  = cnt_d;
    assign fu.fwd_cnt_EM = cnt_em;
    assign fu.fwd_cnt_EW = cnt_ew;
endmodule

// File: tb/tb_forwarding_unit.sv
// Randomized and directed stimulus against a reference model; a monitor pops expectations each cycle.
module tb_forwarding_unit;
    logic clk;
    logic reset_n;

    forwarding_unit_if #(.CNT_W(16)) bus16();
    forwarding_unit_if #(.CNT_W(2))  bus2();

    forwarding_unit #(.CNT_W(16)) dut16 (.clk(clk), .reset_n(reset_n), .fu(bus16.slave));
    forwarding_unit #(.CNT_W(2))  dut2  (.clk(clk), .reset_n(reset_n), .fu(bus2.slave));

    typedef struct packed {
        logic       rwm;
        logic       rww;
        logic [4:0] rsd;
        logic [4:0] rtd;
        logic [4:0] rse;
        logic [4:0] rte;
        logic [4:0] wm;
        logic [4:0] ww;
    } vec_t;

    typedef struct {
        int fad, fbd, fae, fbe;
        int cd, cem, cew;
        int sd, sem, sew;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // model state: selects currently presented, and counter totals
    int cur_fad = 0, cur_fbd = 0, cur_fae = 0, cur_fbe = 0;
    int m_cd = 0, m_cem = 0, m_cew = 0;
    int m_sd = 0, m_sem = 0, m_sew = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int rwm, rww, rsd, rtd, rse, rte, wm, ww);
        vec_t v;
        v.rwm = rwm[0]; v.rww = rww[0];
        v.rsd = rsd[4:0]; v.rtd = rtd[4:0]; v.rse = rse[4:0]; v.rte = rte[4:0];
        v.wm = wm[4:0]; v.ww = ww[4:0];
        return v;
    endfunction

    // Producers are listed youngest first; the first live writer of the source supplies it.
    function automatic int model_exe(input logic [4:0] src, input vec_t v);
        logic       we[2];
        logic [4:0] dst[2];
        int         code[2];
        we   = '{v.rwm, v.rww};
        dst  = '{v.wm, v.ww};
        code = '{2, 1};
        if (src == 5'd0) return 0;
        for (int i = 0; i < 2; i++)
            if (we[i] && dst[i] == src) return code[i];
        return 0;
    endfunction

    function automatic int model_dec(input logic [4:0] src, input vec_t v);
        return (src != 5'd0 && v.rwm && v.wm == src) ? 1 : 0;
    endfunction

    function automatic int sat_inc(input int c, input int lim);
        return (c < lim) ? c + 1 : c;
    endfunction

    task automatic clock_model();
        if (reset_n) begin
            if (cur_fad == 1 || cur_fbd == 1) begin
                m_cd = sat_inc(m_cd, 65535); m_sd = sat_inc(m_sd, 3);
            end
            if (cur_fae == 2 || cur_fbe == 2) begin
                m_cem = sat_inc(m_cem, 65535); m_sem = sat_inc(m_sem, 3);
            end
            if (cur_fae == 1 || cur_fbe == 1) begin
                m_cew = sat_inc(m_cew, 65535); m_sew = sat_inc(m_sew, 3);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        bus16.regwriteM = v.rwm; bus2.regwriteM = v.rwm;
        bus16.regwriteW = v.rww; bus2.regwriteW = v.rww;
        bus16.rsD = v.rsd;       bus2.rsD = v.rsd;
        bus16.rtD = v.rtd;       bus2.rtD = v.rtd;
        bus16.rsE = v.rse;       bus2.rsE = v.rse;
        bus16.rtE = v.rte;       bus2.rtE = v.rte;
        bus16.writeregM = v.wm;  bus2.writeregM = v.wm;
        bus16.writeregW = v.ww;  bus2.writeregW = v.ww;
    endtask

    task automatic apply(input vec_t v, input logic rst);
        exp_t e;
        @(posedge clk);
        clock_model();
        #1;
        reset_n = rst;
        if (!rst) begin
            m_cd = 0; m_cem = 0; m_cew = 0; m_sd = 0; m_sem = 0; m_sew = 0;
        end
        drive(v);
        cur_fad = model_dec(v.rsd, v);
        cur_fbd = model_dec(v.rtd, v);
        cur_fae = model_exe(v.rse, v);
        cur_fbe = model_exe(v.rte, v);
        e.fad = cur_fad; e.fbd = cur_fbd; e.fae = cur_fae; e.fbe = cur_fbe;
        e.cd = m_cd; e.cem = m_cem; e.cew = m_cew;
        e.sd = m_sd; e.sem = m_sem; e.sew = m_sew;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("forwardaD", int'(bus16.forwardaD), e.fad);
                chk("forwardbD", int'(bus16.forwardbD), e.fbd);
                chk("forwardaE", int'(bus16.forwardaE), e.fae);
                chk("forwardbE", int'(bus16.forwardbE), e.fbe);
                chk("fwd_cnt_D", int'(bus16.fwd_cnt_D), e.cd);
                chk("fwd_cnt_EM", int'(bus16.fwd_cnt_EM), e.cem);
                chk("fwd_cnt_EW", int'(bus16.fwd_cnt_EW), e.cew);
                chk("sat_cnt_D", int'(bus2.fwd_cnt_D), e.sd);
                chk("sat_cnt_EM", int'(bus2.fwd_cnt_EM), e.sem);
                chk("sat_cnt_EW", int'(bus2.fwd_cnt_EW), e.sew);
            end
        end
    end

    initial begin : stimulus
        vec_t z;
        vec_t v;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        drive(z);

        apply(z, 0);
        apply(z, 0);
        apply(z, 1);

        // decode A, then decode B
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0), 1);
        apply(mk(1, 0, 5, 0, 0, 0, 2, 0), 1);
        apply(mk(1, 0, 5, 0, 0, 0, 5, 0), 1);
        apply(mk(0, 0, 5, 0, 0, 0, 5, 0), 1);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0), 1);
        apply(mk(1, 0, 0, 5, 0, 0, 2, 0), 1);
        apply(mk(1, 0, 0, 5, 0, 0, 5, 0), 1);
        apply(mk(0, 0, 0, 5, 0, 0, 5, 0), 1);

        // execute A, then execute B
        apply(mk(1, 1, 0, 0, 5, 0, 5, 5), 1);
        apply(mk(1, 1, 0, 0, 0, 0, 5, 5), 1);
        apply(mk(1, 1, 0, 0, 4, 0, 5, 6), 1);
        apply(mk(1, 1, 0, 0, 5, 0, 4, 5), 1);
        apply(mk(1, 1, 0, 0, 0, 5, 5, 5), 1);
        apply(mk(1, 1, 0, 0, 0, 0, 5, 5), 1);
        apply(mk(1, 1, 0, 0, 0, 4, 5, 6), 1);
        apply(mk(1, 1, 0, 0, 0, 5, 4, 5), 1);

        // regwrite gating
        apply(mk(0, 1, 0, 0, 5, 0, 5, 5), 1);
        apply(mk(0, 0, 0, 0, 5, 0, 5, 5), 1);

        // counters: clean reset, hold forwardaD for three edges, then clear mid-count
        apply(z, 0);
        apply(z, 1);
        for (int i = 0; i < 3; i++) apply(mk(1, 0, 5, 0, 0, 0, 5, 0), 1);
        apply(z, 1);
        apply(mk(1, 0, 5, 0, 0, 0, 5, 0), 1);
        apply(mk(1, 0, 5, 0, 0, 0, 5, 0), 0);
        apply(z, 1);

        // saturation of the narrow instance
        for (int i = 0; i < 6; i++) apply(mk(1, 1, 0, 0, 5, 0, 5, 0), 1);
        apply(z, 1);

        for (int i = 0; i < 400; i++) begin
            v.rwm = 1'($urandom_range(0, 1));
            v.rww = 1'($urandom_range(0, 1));
            v.rsd = 5'($urandom_range(0, 7));
            v.rtd = 5'($urandom_range(0, 7));
            v.rse = 5'($urandom_range(0, 7));
            v.rte = 5'($urandom_range(0, 7));
            v.wm  = 5'($urandom_range(0, 7));
            v.ww  = 5'($urandom_range(0, 7));
            apply(v, ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
